exec_unit: RTL and testbench

Multi-cycle execute stage sitting directly upstream of `register_block`: accepts one 16-bit instruction per handshake, drives the register block's two read ports, computes an 8-bit ALU result and drives the register block's write port for exactly one cycle. It is the only writer of `register_block`. It holds architectural flags (zero, carry) and reports completion and illegal opcodes to the fetch/control logic above it.

---
 rtl/exec_pkg.sv | 46 ++++
 rtl/exec_unit_alu8.sv | 52 +++++
 rtl/exec_unit.sv | 140 ++++++++++++++
 tb/tb_exec_unit.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/exec_pkg.sv
// Shared definitions for the execute stage: opcode values, FSM state
// encoding, instruction field positions and opcode classification helpers.
// No logic; imported by exec_unit and alu8.
package exec_pkg;

    localparam int INSTR_W = 16;

    // Instruction layout {opcode, rd, rs1, rs2}
    localparam int OPC_MSB = 15;
    localparam int OPC_LSB = 12;
    localparam int RD_MSB  = 11;
    localparam int RD_LSB  = 8;
    localparam int RS1_MSB = 7;
    localparam int RS1_LSB = 4;
    localparam int RS2_MSB = 3;
    localparam int RS2_LSB = 0;

    localparam logic [3:0] OP_NOP = 4'd0;
    localparam logic [3:0] OP_ADD = 4'd1;
    localparam logic [3:0] OP_SUB = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SHL = 4'd6;
    localparam logic [3:0] OP_SHR = 4'd7;
    localparam logic [3:0] OP_LDI = 4'd8;
    localparam logic [3:0] OP_MOV = 4'd9;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_EXEC  = 2'd2,
        ST_WRITE = 2'd3
    } state_e;

    // Opcodes that produce a result: they write rd and update flag_zero.
    function automatic logic op_writes(input logic [3:0] op);
        return (op >= OP_ADD) && (op <= OP_MOV);
    endfunction

    // Only ADD/SUB touch flag_carry; everything else holds it.
    function automatic logic op_sets_carry(input logic [3:0] op);
        return (op == OP_ADD) || (op == OP_SUB);
    endfunction

endpackage

// File: rtl/exec_unit_alu8.sv
// alu8: combinational ALU for the execute stage.
// Latency: zero cycles (pure combinational).
// Backpressure: none; the caller samples the outputs when it needs them.
// Ports: op_i opcode, a_i/b_i operands, imm_i LDI immediate;
//        result_o wrapped result, carry_o carry/borrow, illegal_o undefined opcode.
module alu8
    import exec_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic [3:0]       op_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic [WIDTH-1:0] imm_i,
    output logic [WIDTH-1:0] result_o,
    output logic             carry_o,
    output logic             illegal_o
);

    logic [WIDTH:0] sum;
    logic [WIDTH:0] diff;

    // One extra bit: sum MSB is the carry, diff MSB is the unsigned borrow.
    assign sum  = {1'b0, a_i} + {1'b0, b_i};
    assign diff = {1'b0, a_i} - {1'b0, b_i};

    always_comb begin
        result_o  = '0;
        carry_o   = 1'b0;
        illegal_o = 1'b0;
        case (op_i)
            OP_NOP: result_o = '0;
            OP_ADD: begin
                result_o = sum[WIDTH-1:0];
                carry_o  = sum[WIDTH];
            end
            OP_SUB: begin
                result_o = diff[WIDTH-1:0];
                carry_o  = diff[WIDTH];
            end
            OP_AND: result_o = a_i & b_i;
            OP_OR:  result_o = a_i | b_i;
            OP_XOR: result_o = a_i ^ b_i;
            OP_SHL: result_o = a_i << b_i[2:0];
            OP_SHR: result_o = a_i >> b_i[2:0];
            OP_LDI: result_o = imm_i;
            OP_MOV: result_o = a_i;
            default: illegal_o = 1'b1;
        endcase
    end

endmodule

// File: rtl/exec_unit.sv
// exec_unit: four-state execute stage (IDLE/READ/EXEC/WRITE) feeding register_block.
// Latency: accept edge -> READ -> EXEC -> WRITE, 4 cycles per instruction.
// Backpressure: instr_ready high only in IDLE; no stalls once accepted.
// Ports: clock/reset_n; instr_valid/instr/instr_ready upstream handshake;
//        read{1,2}_id/_value register reads; write_id/write_value register write;
//        done/illegal completion pulses; flag_zero/flag_carry architectural flags.
module exec_unit
    import exec_pkg::*;
#(
    parameter int WIDTH    = 8,
    parameter int REG_ID_W = 4
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                instr_valid,
    input  logic [INSTR_W-1:0]  instr,
    output logic                instr_ready,
    output logic [REG_ID_W-1:0] read1_id,
    input  logic [WIDTH-1:0]    read1_value,
    output logic [REG_ID_W-1:0] read2_id,
    input  logic [WIDTH-1:0]    read2_value,
    output logic [REG_ID_W-1:0] write_id,
    output logic [WIDTH-1:0]    write_value,
    output logic                done,
    output logic                illegal,
    output logic                flag_zero,
    output logic                flag_carry
);

    state_e              state_q;
    logic [INSTR_W-1:0]  instr_q;
    logic [WIDTH-1:0]    a_q;
    logic [WIDTH-1:0]    b_q;
    // result/carry/illegal are loaded at the end of EXEC and cleared when
    // WRITE ends, so they are nonzero only during WRITE and double as outputs.
    logic [WIDTH-1:0]    result_q;
    logic                carry_q;
    logic                illegal_q;
    logic                done_q;
    logic                instr_ready_q;
    logic [REG_ID_W-1:0] read1_id_q;
    logic [REG_ID_W-1:0] read2_id_q;
    logic [REG_ID_W-1:0] write_id_q;
    logic                flag_zero_q;
    logic                flag_carry_q;

    logic [3:0]          op;
    logic [WIDTH-1:0]    alu_result;
    logic                alu_carry;
    logic                alu_illegal;

    assign op = instr_q[OPC_MSB:OPC_LSB];

    alu8 #(.WIDTH(WIDTH)) u_alu (
        .op_i      (op),
        .a_i       (a_q),
        .b_i       (b_q),
        .imm_i     (WIDTH'(instr_q[RS1_MSB:RS2_LSB])),
        .result_o  (alu_result),
        .carry_o   (alu_carry),
        .illegal_o (alu_illegal)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            instr_q       <= '0;
            a_q           <= '0;
            b_q           <= '0;
            result_q      <= '0;
            carry_q       <= 1'b0;
            illegal_q     <= 1'b0;
            done_q        <= 1'b0;
            instr_ready_q <= 1'b1;
            read1_id_q    <= '0;
            read2_id_q    <= '0;
            write_id_q    <= '0;
            flag_zero_q   <= 1'b0;
            flag_carry_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (instr_valid) begin
                        instr_q       <= instr;
                        instr_ready_q <= 1'b0;
                        // Read ids come straight from the accepted word so
                        // they are already registered during READ.
                        read1_id_q    <= REG_ID_W'(instr[RS1_MSB:RS1_LSB]);
                        read2_id_q    <= REG_ID_W'(instr[RS2_MSB:RS2_LSB]);
                        state_q       <= ST_READ;
                    end
                end
                ST_READ: begin
                    a_q        <= read1_value;
                    b_q        <= read2_value;
                    read1_id_q <= '0;
                    read2_id_q <= '0;
                    state_q    <= ST_EXEC;
                end
                ST_EXEC: begin
                    result_q   <= alu_result;
                    carry_q    <= alu_carry;
                    illegal_q  <= alu_illegal;
                    done_q     <= 1'b1;
                    // NOP and illegal opcodes present write_id 0, i.e. no write.
                    write_id_q <= op_writes(op) ? REG_ID_W'(instr_q[RD_MSB:RD_LSB])
                                                : '0;
                    state_q    <= ST_WRITE;
                end
                ST_WRITE: begin
                    if (op_writes(op)) begin
                        flag_zero_q <= (result_q == '0);
                    end
                    if (op_sets_carry(op)) begin
                        flag_carry_q <= carry_q;
                    end
                    result_q      <= '0;
                    carry_q       <= 1'b0;
                    illegal_q     <= 1'b0;
                    done_q        <= 1'b0;
                    write_id_q    <= '0;
                    instr_ready_q <= 1'b1;
                    state_q       <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    assign instr_ready = instr_ready_q;
    assign read1_id    = read1_id_q;
    assign read2_id    = read2_id_q;
    assign write_id    = write_id_q;
    assign write_value = result_q;
    assign done        = done_q;
    assign illegal     = illegal_q;
    assign flag_zero   = flag_zero_q;
    assign flag_carry  = flag_carry_q;

endmodule

// File: tb/tb_exec_unit.sv
// Bench for exec_unit: a behavioural register_block, a directed vector
// table, hand sequences for back-to-back handshakes and mid-instruction
// reset, then random instructions checked against an arithmetic model.
module tb_exec_unit;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        instr_valid;
    logic [15:0] instr;
    logic        instr_ready;
    logic [3:0]  read1_id;
    logic [7:0]  read1_value;
    logic [3:0]  read2_id;
    logic [7:0]  read2_value;
    logic [3:0]  write_id;
    logic [7:0]  write_value;
    logic        done;
    logic        illegal;
    logic        flag_zero;
    logic        flag_carry;

    int checks   = 0;
    int failures = 0;

    always #5 clock = ~clock;

    exec_unit #(.WIDTH(8), .REG_ID_W(4)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .instr_valid (instr_valid),
        .instr       (instr),
        .instr_ready (instr_ready),
        .read1_id    (read1_id),
        .read1_value (read1_value),
        .read2_id    (read2_id),
        .read2_value (read2_value),
        .write_id    (write_id),
        .write_value (write_value),
        .done        (done),
        .illegal     (illegal),
        .flag_zero   (flag_zero),
        .flag_carry  (flag_carry)
    );

    // Behavioural register_block: combinational reads, r0 reads zero.
    logic [7:0] rf [16];
    logic       rf_clr = 1'b1;
    always @(posedge clock) begin
        if (rf_clr) begin
            for (int i = 0; i < 16; i++) rf[i] <= 8'h00;
        end else if (write_id != 4'd0) begin
            rf[write_id] <= write_value;
        end
    end
    assign read1_value = (read1_id == 4'd0) ? 8'h00 : rf[read1_id];
    assign read2_value = (read2_id == 4'd0) ? 8'h00 : rf[read2_id];

    // Architectural reference model.
    logic [7:0] mregs [16];
    bit         mz;
    bit         mc;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic model_step(input logic [15:0] ins, output logic [3:0] wid,
                              output logic [7:0] wval, output bit wr, output bit ill);
        int op, rd, s1, s2, a, b, res;
        op  = int'(ins[15:12]);
        rd  = int'(ins[11:8]);
        s1  = int'(ins[7:4]);
        s2  = int'(ins[3:0]);
        a   = (s1 == 0) ? 0 : int'(mregs[s1]);
        b   = (s2 == 0) ? 0 : int'(mregs[s2]);
        res = 0;
        wr  = 1'b1;
        ill = 1'b0;
        case (op)
            1: begin res = a + b; mc = (res > 255); res = res % 256; end
            2: begin mc = (a < b); res = a - b; if (res < 0) res += 256; end
            3: res = a & b;
            4: res = a | b;
            5: res = a ^ b;
            6: res = (a * (1 << (b % 8))) % 256;
            7: res = a / (1 << (b % 8));
            8: res = s1 * 16 + s2;
            9: res = a;
            default: begin wr = 1'b0; ill = (op >= 10); end
        endcase
        if (wr) begin
            mz = (res == 0);
            if (rd != 0) mregs[rd] = 8'(res);
        end
        wid  = (wr && rd != 0) ? 4'(rd) : 4'd0;
        wval = 8'(res);
    endtask

    // Issue one instruction and follow it through READ/EXEC/WRITE, checking
    // the per-cycle protocol; returns what was seen in the WRITE cycle.
    // Ends at the negedge of the IDLE cycle after WRITE.
    task automatic do_instr(input logic [15:0] ins, input bit hold,
                            output logic [3:0] wid, output logic [7:0] wval,
                            output bit dn, output bit il);
        int n;
        wid = 4'd0; wval = 8'h00; dn = 1'b0; il = 1'b0;
        @(negedge clock);
        instr_valid = 1'b1;
        instr       = ins;
        n = 0;
        while (!instr_ready && n < 20) begin
            @(negedge clock);
            n++;
        end
        if (n >= 20) begin
            chk("accept_timeout", 32'(n), 32'd0);
            instr_valid = 1'b0;
            return;
        end
        @(negedge clock); // READ
        instr       = ~ins;      // must be ignored while busy
        instr_valid = hold;
        chk("read_ready", 32'(instr_ready), 32'd0);
        chk("read1_id", 32'(read1_id), 32'(ins[7:4]));
        chk("read2_id", 32'(read2_id), 32'(ins[3:0]));
        chk("read_wid", 32'(write_id), 32'd0);
        @(negedge clock); // EXEC
        chk("exec_ready", 32'(instr_ready), 32'd0);
        chk("exec_rids", 32'({read1_id, read2_id}), 32'd0);
        chk("exec_wr", 32'({write_id, write_value, done, illegal}), 32'd0);
        @(negedge clock); // WRITE
        chk("write_ready", 32'(instr_ready), 32'd0);
        chk("write_rids", 32'({read1_id, read2_id}), 32'd0);
        wid  = write_id;
        wval = write_value;
        dn   = done;
        il   = illegal;
        instr_valid = 1'b0;
        @(negedge clock); // IDLE
        chk("idle_ready", 32'(instr_ready), 32'd1);
        chk("idle_wr", 32'({write_id, write_value, done, illegal}), 32'd0);
    endtask

    typedef struct {
        logic [15:0] ins;
        bit          hold;
        logic [3:0]  wid;
        logic [7:0]  wval;
        bit          chk_val;
        bit          ill;
        bit          z;
        bit          c;
    } vec_t;

    vec_t tbl [17];

    initial begin
        logic [3:0] wid, mwid;
        logic [7:0] wval, mwval;
        bit         dn, il, mwr, mill, bad;
        logic [11:0] done_pat, rdy_pat;
        logic [15:0] ins;

        tbl[0]  = '{16'h8255, 0, 4'd2,  8'h55, 1, 0, 0, 0};
        tbl[1]  = '{16'h81F0, 0, 4'd1,  8'hF0, 1, 0, 0, 0};
        tbl[2]  = '{16'h8220, 0, 4'd2,  8'h20, 1, 0, 0, 0};
        tbl[3]  = '{16'h1312, 0, 4'd3,  8'h10, 1, 0, 0, 1};
        tbl[4]  = '{16'h2421, 0, 4'd4,  8'h30, 1, 0, 0, 1};
        tbl[5]  = '{16'h5511, 0, 4'd5,  8'h00, 1, 0, 1, 1};
        tbl[6]  = '{16'h1012, 0, 4'd0,  8'h10, 1, 0, 0, 1};
        tbl[7]  = '{16'hC123, 1, 4'd0,  8'h00, 0, 1, 0, 1};
        tbl[8]  = '{16'h8709, 0, 4'd7,  8'h09, 1, 0, 0, 1};
        tbl[9]  = '{16'h6617, 0, 4'd6,  8'hE0, 1, 0, 0, 1};
        tbl[10] = '{16'h7617, 1, 4'd6,  8'h78, 1, 0, 0, 1};
        tbl[11] = '{16'h0345, 0, 4'd0,  8'h00, 0, 0, 0, 1};
        tbl[12] = '{16'h9860, 0, 4'd8,  8'h78, 1, 0, 0, 1};
        tbl[13] = '{16'h3917, 0, 4'd9,  8'h00, 1, 0, 1, 1};
        tbl[14] = '{16'h4A17, 0, 4'd10, 8'hF9, 1, 0, 0, 1};
        tbl[15] = '{16'h2B22, 0, 4'd11, 8'h00, 1, 0, 1, 0};
        tbl[16] = '{16'h1C77, 0, 4'd12, 8'h12, 1, 0, 0, 0};

        for (int i = 0; i < 16; i++) mregs[i] = 8'h00;
        mz = 1'b0;
        mc = 1'b0;

        // Reset state
        reset_n     = 1'b0;
        instr_valid = 1'b0;
        instr       = 16'h0000;
        #3;
        chk("rst_outputs", 32'({read1_id, read2_id, write_id, write_value,
                                done, illegal, flag_zero, flag_carry}), 32'd0);
        @(negedge clock);
        rf_clr = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("rst_ready", 32'(instr_ready), 32'd1);

        // Directed vector table
        for (int i = 0; i < 17; i++) begin
            model_step(tbl[i].ins, mwid, mwval, mwr, mill);
            do_instr(tbl[i].ins, tbl[i].hold, wid, wval, dn, il);
            chk($sformatf("tbl%0d_wid", i), 32'(wid), 32'(tbl[i].wid));
            if (tbl[i].chk_val) chk($sformatf("tbl%0d_wval", i), 32'(wval), 32'(tbl[i].wval));
            chk($sformatf("tbl%0d_done", i), 32'(dn), 32'd1);
            chk($sformatf("tbl%0d_ill", i), 32'(il), 32'(tbl[i].ill));
            chk($sformatf("tbl%0d_flags", i), 32'({flag_zero, flag_carry}),
                32'({tbl[i].z, tbl[i].c}));
        end
        chk("rf_r2", 32'(rf[2]), 32'h20);
        chk("rf_r3", 32'(rf[3]), 32'h10);
        chk("rf_r6", 32'(rf[6]), 32'h78);

        // Valid held high continuously: accepts exactly every 4 cycles
        ins = 16'h8D3C;
        @(negedge clock);
        instr_valid = 1'b1;
        instr       = ins;
        done_pat = '0;
        rdy_pat  = '0;
        for (int k = 1; k <= 12; k++) begin
            @(negedge clock);
            done_pat[k-1] = done;
            rdy_pat[k-1]  = instr_ready;
        end
        instr_valid = 1'b0;
        for (int k = 0; k < 3; k++) model_step(ins, mwid, mwval, mwr, mill);
        chk("b2b_done_pattern", 32'(done_pat), 32'b0100_0100_0100);
        chk("b2b_ready_pattern", 32'(rdy_pat), 32'b1000_1000_1000);
        chk("b2b_rf_r13", 32'(rf[13]), 32'h3C);

        // Reset during EXEC of ADD r3,r1,r2: no write, outputs clear at once
        model_step(16'h83AA, mwid, mwval, mwr, mill);
        do_instr(16'h83AA, 0, wid, wval, dn, il);
        chk("pre_abort_r3", 32'(rf[3]), 32'hAA);
        model_step(16'h1012, mwid, mwval, mwr, mill); // sets carry so reset has work to do
        do_instr(16'h1012, 0, wid, wval, dn, il);
        @(negedge clock);
        instr_valid = 1'b1;
        instr       = 16'h1312;
        @(negedge clock); // READ
        instr_valid = 1'b0;
        @(negedge clock); // EXEC
        #2;
        reset_n = 1'b0;
        #1;
        chk("abort_outputs", 32'({read1_id, read2_id, write_id, write_value,
                                  done, illegal, flag_zero, flag_carry}), 32'd0);
        mz = 1'b0;
        mc = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
        #1;
        chk("abort_ready", 32'(instr_ready), 32'd1);
        bad = 1'b0;
        for (int k = 0; k < 6; k++) begin
            @(negedge clock);
            if (write_id != 4'd0 || done) bad = 1'b1;
        end
        chk("abort_no_write", 32'(bad), 32'd0);
        chk("abort_r3_kept", 32'(rf[3]), 32'hAA);
        model_step(16'h1312, mwid, mwval, mwr, mill);
        do_instr(16'h1312, 0, wid, wval, dn, il);
        chk("post_abort_wid", 32'(wid), 32'd3);
        chk("post_abort_wval", 32'(wval), 32'h10);
        chk("post_abort_flags", 32'({flag_zero, flag_carry}), 32'b01);

        // Random instructions against the reference model
        for (int i = 0; i < 80; i++) begin
            ins = 16'($urandom);
            model_step(ins, mwid, mwval, mwr, mill);
            do_instr(ins, 1'($urandom_range(0, 1)), wid, wval, dn, il);
            chk($sformatf("rnd%0d_wid ins=%h", i, ins), 32'(wid), 32'(mwid));
            if (mwr) chk($sformatf("rnd%0d_wval ins=%h", i, ins), 32'(wval), 32'(mwval));
            chk($sformatf("rnd%0d_done", i), 32'(dn), 32'd1);
            chk($sformatf("rnd%0d_ill ins=%h", i, ins), 32'(il), 32'(mill));
            chk($sformatf("rnd%0d_flags ins=%h", i, ins), 32'({flag_zero, flag_carry}),
                32'({mz, mc}));
        end
        for (int r = 1; r < 16; r++) begin
            chk($sformatf("final_r%0d", r), 32'(rf[r]), 32'(mregs[r]));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
